useless_boxes: RTL and testbench
================================

Name: useless_boxes

Overview:
- Controller for an array of N "useless boxes". Each box has a toggle switch input and an arm servo driven by a PWM output.
- When a user turns a switch on, that box's servo pulse moves to the PUSH position so the arm flips the switch back off. The arm then returns to REST.
- Sits between board switch pins and servo headers. All boxes share one PWM frame timer.

Parameters:
- N_BOX, 10, number of boxes (switch/PWM width).
- FRAME_CYCLES, 2000000, PWM frame period in clk cycles (20 ms at 100 MHz).
- REST_CYCLES, 100000, high time for the REST (arm retracted) pulse (1 ms).
- PUSH_CYCLES, 200000, high time for the PUSH (arm extended) pulse (2 ms); must be greater than REST_CYCLES and less than FRAME_CYCLES.
- RETRACT_FRAMES, 25, frames spent in RETRACT after the switch goes off (0.5 s).

Ports:
- clk  in  1  system clock (100 MHz nominal).
- reset  in  1  asynchronous, active-low reset.
- switch  in  N_BOX  raw asynchronous switch levels; 1 = on.
- PWM  out  N_BOX  servo pulse outputs, one per box.

Behaviour:
- Synchronizer: each switch bit passes through a 2-flop synchronizer (sw_s). Latency from switch to sw_s is 2 cycles.
- Frame counter: frame_cnt counts 0..FRAME_CYCLES-1 and wraps to 0. frame_start = (frame_cnt==0).
- Per-box FSM states:
  - IDLE: arm at rest. If sw_s[i]==1, go to PUSH.
  - PUSH: arm extended. Stay while sw_s[i]==1. When sw_s[i]==0, go to RETRACT and load rcnt[i]=RETRACT_FRAMES.
  - RETRACT: arm returning. Decrement rcnt[i] on each frame_start. When rcnt reaches 0, go to IDLE. If sw_s[i]==1 again (toggled back on mid-retract), go directly to PUSH; rcnt is ignored.
- Pulse width target: PUSH selects PUSH_CYCLES. IDLE and RETRACT select REST_CYCLES.
- Width latching: width[i] loads the target only on frame_start, so there are never partial or glitched pulses. An FSM change therefore affects PWM from the next frame boundary. Worst-case latency is 3 cycles plus one frame.
- PWM[i] = registered (frame_cnt < width[i]). Output is high for exactly width[i] cycles per frame, starting at frame_cnt==0 (one-cycle register delay relative to the counter).
- Boxes are fully independent. Any number may be in PUSH simultaneously.
- Reset, asserted at any time including mid-pulse:
  - frame_cnt=0, all FSMs IDLE, rcnt=0.
  - width[i]=REST_CYCLES.
  - sync flops=0, PWM=0 immediately.
  - After release, the first frame begins with a REST pulse on every output.
- Arithmetic: counters are sized with $clog2(FRAME_CYCLES) and $clog2(RETRACT_FRAMES+1). No overflow is possible because wrap is explicit.
- Unknown or X switch bits after synchronization are treated as 0.

Optional Feature:
- Macro DEBOUNCE_EN.
- Defined: each synchronized switch bit also passes through a debouncer. The debounced value changes only after the raw synchronized value has been stable for DEBOUNCE_CYCLES (additional parameter, default 1000000 = 10 ms). The FSM uses the debounced value. Debounced reset value is 0.
- Undefined: the FSM uses sw_s directly, and the DEBOUNCE_CYCLES parameter is unused.

Decomposition:
- Package useless_boxes_pkg:
  - enum box_state_t {IDLE, PUSH, RETRACT} (2 bits).
  - Default timing localparams, including DEFAULT_FRAME_CYCLES.
- One natural sub-module: box_ctrl, holding per-box FSM, rcnt and width register. It is instantiated N_BOX times with a generate loop. The frame counter and synchronizers stay in the top level.

Test Plan (FRAME_CYCLES=100, REST_CYCLES=10, PUSH_CYCLES=20, RETRACT_FRAMES=2):
- Reset: reset low for 3 cycles then high, switch=0 -> PWM=0 during reset; then every bit is high 10 of 100 cycles each frame.
- Single push: switch=10'b1000000000 mid-frame -> PWM[9] is 20 cycles high from the next frame_start; PWM[8:0] stay at 10-cycle pulses.
- Release: drop switch[9] -> after 3 cycles box 9 enters RETRACT; next frame PWM[9]=10 cycles; returns to IDLE after 2 frame_starts.
- Re-trigger: raise switch[9] again during RETRACT -> next frame PWM[9]=20 cycles; no wait for rcnt.
- All boxes: switch=10'h3FF -> all PWM bits 20 cycles high in the same frame; reset mid-pulse -> PWM=0 immediately, FSMs IDLE.
- DEBOUNCE_EN (DEBOUNCE_CYCLES=5): 3-cycle glitch on switch[0] -> no state change; a stable 6-cycle high -> PUSH.

Source files
------------

// File: rtl/useless_boxes_pkg.sv
// Shared types and default timing for the useless_boxes servo controller.
// Timing defaults assume a 100 MHz clock and standard 50 Hz hobby servos.
package useless_boxes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH    = 2'd1,
    RETRACT = 2'd2
  } box_state_t;

  localparam int DEFAULT_N_BOX           = 10;
  localparam int DEFAULT_FRAME_CYCLES    = 2000000;
  localparam int DEFAULT_REST_CYCLES     = 100000;
  localparam int DEFAULT_PUSH_CYCLES     = 200000;
  localparam int DEFAULT_RETRACT_FRAMES  = 25;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // Pulse high time for a given arm position.
  function automatic int pulse_cycles(input box_state_t st, input int push_c, input int rest_c);
    int res;
    case (st)
      PUSH:    res = push_c;
      default: res = rest_c;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/useless_boxes_box_ctrl.sv
// One box: arm FSM, retract frame counter, frame-latched pulse width and
// the registered PWM comparator against the shared frame counter.
module box_ctrl
  import useless_boxes_pkg::*;
#(
  parameter int FRAME_CYCLES   = DEFAULT_FRAME_CYCLES,
  parameter int REST_CYCLES    = DEFAULT_REST_CYCLES,
  parameter int PUSH_CYCLES    = DEFAULT_PUSH_CYCLES,
  parameter int RETRACT_FRAMES = DEFAULT_RETRACT_FRAMES,
  parameter int FW             = $clog2(FRAME_CYCLES),
  parameter int RW             = $clog2(RETRACT_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sw,
  input  logic          frame_start,
  input  logic [FW-1:0] frame_cnt,
  output logic          pwm
);

  localparam logic [RW-1:0] RETRACT_LOAD = RW'(RETRACT_FRAMES);
  localparam logic [RW-1:0] RCNT_ONE     = RW'(1);

  box_state_t    state;
  box_state_t    state_next;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_next;
  logic [FW-1:0] width;
  logic [FW-1:0] width_target;

  // Next-state logic; a switch turned back on always wins over the retract timer.
  always_comb begin
    state_next   = state;
    rcnt_next    = rcnt;
    width_target = FW'(pulse_cycles(state, PUSH_CYCLES, REST_CYCLES));
    case (state)
      IDLE: begin
        if (sw) state_next = PUSH;
        else    state_next = IDLE;
      end
      PUSH: begin
        if (!sw) begin
          state_next = RETRACT;
          rcnt_next  = RETRACT_LOAD;
        end else begin
          state_next = PUSH;
        end
      end
      RETRACT: begin
        if (sw) begin
          state_next = PUSH;
          rcnt_next  = '0;
        end else if (frame_start) begin
          if (rcnt <= RCNT_ONE) begin
            state_next = IDLE;
            rcnt_next  = '0;
          end else begin
            rcnt_next = rcnt - RCNT_ONE;
          end
        end else begin
          state_next = RETRACT;
        end
      end
      default: begin
        state_next = IDLE;
        rcnt_next  = '0;
      end
    endcase
  end

  // State, timer, width (only at frame boundaries) and registered PWM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rcnt  <= '0;
      width <= FW'(REST_CYCLES);
      pwm   <= 1'b0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
      if (frame_start) width <= width_target;
      else             width <= width;
      pwm <= (frame_cnt < width);
    end
  end

endmodule

// File: rtl/useless_boxes.sv
// Top of the useless_boxes controller: switch synchronizers, shared frame timer, N_BOX box_ctrl.
// Optional macro DEBOUNCE_EN inserts a per-switch debouncer of DEBOUNCE_CYCLES.
module useless_boxes
  import useless_boxes_pkg::*;
#(
  parameter int N_BOX           = DEFAULT_N_BOX,
  parameter int FRAME_CYCLES    = DEFAULT_FRAME_CYCLES,
  parameter int REST_CYCLES     = DEFAULT_REST_CYCLES,
  parameter int PUSH_CYCLES     = DEFAULT_PUSH_CYCLES,
  parameter int RETRACT_FRAMES  = DEFAULT_RETRACT_FRAMES
`ifdef DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BOX-1:0] switch,
  output logic [N_BOX-1:0] PWM
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int RW = $clog2(RETRACT_FRAMES + 1);

  logic [N_BOX-1:0] sync_meta;
  logic [N_BOX-1:0] sw_s;
  logic [N_BOX-1:0] sw_use;
  logic [FW-1:0]    frame_cnt;
  logic             frame_start;

  // Two-flop synchronizer for the raw switch pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sw_s      <= '0;
    end else begin
      sync_meta <= switch;
      sw_s      <= sync_meta;
    end
  end

  // Shared frame timer with explicit wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FW'(FRAME_CYCLES - 1)) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FW'(1);
    end
  end

  assign frame_start = (frame_cnt == '0);

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar d = 0; d < N_BOX; d++) begin : g_db
    logic [DW-1:0] db_cnt;

    // Debounced level follows sw_s only after DEBOUNCE_CYCLES of disagreement.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        db_cnt    <= '0;
        sw_use[d] <= 1'b0;
      end else if (sw_s[d] == sw_use[d]) begin
        db_cnt    <= '0;
        sw_use[d] <= sw_use[d];
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt    <= '0;
        sw_use[d] <= sw_s[d];
      end else begin
        db_cnt    <= db_cnt + DW'(1);
        sw_use[d] <= sw_use[d];
      end
    end
  end
`else
  assign sw_use = sw_s;
`endif

  for (genvar i = 0; i < N_BOX; i++) begin : g_box
    box_ctrl #(
      .FRAME_CYCLES  (FRAME_CYCLES),
      .REST_CYCLES   (REST_CYCLES),
      .PUSH_CYCLES   (PUSH_CYCLES),
      .RETRACT_FRAMES(RETRACT_FRAMES),
      .FW            (FW),
      .RW            (RW)
    ) u_box (
      .clk        (clk),
      .reset      (reset),
      .sw         (sw_use[i]),
      .frame_start(frame_start),
      .frame_cnt  (frame_cnt),
      .pwm        (PWM[i])
    );
  end

endmodule

// File: tb/tb_useless_boxes.sv
// Self-checking bench for useless_boxes (default build, small frame timing).
// Reference: each frame's pulse is PUSH-wide iff the twice-synchronized switch was on at the frame boundary.
module tb_useless_boxes;

  localparam int N     = 10;
  localparam int FRAME = 100;
  localparam int REST  = 10;
  localparam int PUSHW = 20;
  localparam int RETR  = 2;

  logic         clk;
  logic         reset;
  logic [N-1:0] switch;
  logic [N-1:0] PWM;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           m_cnt;
  int           m_wid [N];
  logic [N-1:0] m_s1, m_s2, m_on, m_exp;

  useless_boxes #(
    .N_BOX         (N),
    .FRAME_CYCLES  (FRAME),
    .REST_CYCLES   (REST),
    .PUSH_CYCLES   (PUSHW),
    .RETRACT_FRAMES(RETR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .switch(switch),
    .PWM   (PWM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_s1  = '0;
    m_s2  = '0;
    m_on  = '0;
    m_exp = '0;
    for (int i = 0; i < N; i++) m_wid[i] = REST;
  endtask

  // One clock edge of the reference: output for this frame position, then advance.
  task automatic model_edge(input logic [N-1:0] sw);
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) m_exp[i] = (m_cnt < m_wid[i]);
      if (m_cnt == 0)
        for (int i = 0; i < N; i++) m_wid[i] = m_on[i] ? PUSHW : REST;
      m_on  = m_s2;
      m_s2  = m_s1;
      m_s1  = sw;
      m_cnt = (m_cnt + 1) % FRAME;
    end
  endtask

  task automatic step(input logic [N-1:0] sw, input string tag);
    switch = sw;
    @(posedge clk);
    model_edge(sw);
    @(negedge clk);
    check_val(tag, 32'(PWM), 32'(m_exp));
  endtask

  task automatic hold(input logic [N-1:0] sw, input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) step(sw, tag);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    check_val("reset_pwm_now", 32'(PWM), 32'(0));
    model_reset();
    for (int k = 0; k < cycles; k++) step('0, "reset_hold");
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b1;
    switch = '0;
    model_reset();
    #2;
    do_reset(3);

    // Idle frames: every box at REST
    hold('0, 150, "rest_frames");
    // Single push arriving mid-frame, held across frames
    hold(10'b10_0000_0000, 250, "single_push");
    // Release into retract, then re-trigger before the timer runs out
    hold('0, 60, "release");
    hold(10'b10_0000_0000, 150, "retrigger");
    hold('0, 320, "retract_to_idle");
    // All boxes pushing together
    hold(10'h3FF, 105, "all_push");
    // Reset while pulses are high
    for (int k = 0; k < FRAME && m_cnt != 5; k++) step(10'h3FF, "all_push_align");
    check_val("reset_point_pwm", 32'(PWM), 32'h3FF);
    do_reset(3);
    hold('0, 120, "after_reset");

    // Randomized switch patterns with random hold lengths
    for (int seg = 0; seg < 25; seg++) begin
      logic [N-1:0] pat;
      pat = N'($urandom);
      hold(pat, $urandom_range(1, 180), "random");
      if (seg == 12) do_reset($urandom_range(1, 4));
    end
    hold('0, 2 * FRAME, "final_rest");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
